// File: rtl/io_bus_hub.sv
// io_bus_hub: decodes CPU IO bus cycles onto NUM_DEV peripheral slots.
// Each slot has a wait-state count and an enable, written through the cfg port.
// The CPU sees a registered request/ack handshake; accesses to disabled slots are
// counted in err_count.
// Optional macro IO_READY_TIMEOUT_EN: the strobe is stretched until the slot's
// dev_rdy is high, and is aborted after TIMEOUT strobe cycles (sets timeout_flag).
module io_bus_hub #(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WAIT_W  = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  // CPU side
  input  logic                                cpu_cyc,
  input  logic                                cpu_we,
  input  logic [ADDR_W-1:0]                   cpu_addr,
  input  logic [DATA_W-1:0]                   cpu_wdata,
  output logic [DATA_W-1:0]                   cpu_rdata,
  output logic                                cpu_ack,
  // device side
  output logic [ADDR_W-$clog2(NUM_DEV)-1:0]   dev_addr,
  output logic [DATA_W-1:0]                   dev_wdata,
  output logic [NUM_DEV-1:0]                  dev_we,
  output logic [NUM_DEV-1:0]                  dev_re,
  input  logic [NUM_DEV*DATA_W-1:0]           dev_rdata,
  input  logic [NUM_DEV-1:0]                  dev_rdy,
  // configuration
  input  logic                                cfg_we,
  input  logic [$clog2(NUM_DEV)-1:0]          cfg_idx,
  input  logic [WAIT_W-1:0]                   cfg_wait,
  input  logic                                cfg_en,
  // status
  output logic [7:0]                          err_count,
  output logic                                timeout_flag
);

  localparam int unsigned IDX_W = $clog2(NUM_DEV);
  localparam int unsigned DA_W  = ADDR_W - IDX_W;

  typedef enum logic [2:0] {StIdle, StWait, StStrobe, StAck, StDone} state_e;

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_q [NUM_DEV];
  logic [NUM_DEV-1:0]  en_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                we_q;
  logic                hit_q;   // slot was enabled when the strobe began
  logic                ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DA_W-1:0]     addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NUM_DEV-1:0]  we_str_q;
  logic [NUM_DEV-1:0]  re_str_q;
  logic [7:0]          err_q;

  logic [IDX_W-1:0]    go_idx;
  logic                go_we;
  logic [NUM_DEV-1:0]  go_sel;
  logic                enter_strobe;
  logic [DATA_W-1:0]   slot_rdata;
  logic                strobe_done;
  logic                strobe_abort;

`ifdef IO_READY_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     tcnt_q;
  logic                tflag_q;
  logic                slot_rdy;
`else
  logic                unused_rdy;
  logic                unused_cfg;
  assign unused_rdy = ^dev_rdy;
  assign unused_cfg = (TIMEOUT == 0);
`endif

  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign dev_we    = we_str_q;
  assign dev_re    = re_str_q;
  assign err_count = err_q;
`ifdef IO_READY_TIMEOUT_EN
  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // Slot/direction of the access about to strobe: live CPU inputs in IDLE, latched otherwise.
  always_comb begin
    go_idx = idx_q;
    go_we  = we_q;
    if (state_q == StIdle) begin
      go_idx = cpu_addr[ADDR_W-1 -: IDX_W];
      go_we  = cpu_we;
    end
    go_sel         = '0;
    go_sel[go_idx] = en_q[go_idx];
    enter_strobe   = ((state_q == StIdle) && cpu_cyc && (wait_q[go_idx] == '0)) ||
                     ((state_q == StWait) && (cnt_q == '0));
  end

  // Strobe completion: always one cycle, or wait for ready / timeout when enabled.
  always_comb begin
    slot_rdata = dev_rdata[idx_q*DATA_W +: DATA_W];
`ifdef IO_READY_TIMEOUT_EN
    slot_rdy     = dev_rdy[idx_q];
    strobe_abort = hit_q && !slot_rdy && (tcnt_q == TO_W'(TIMEOUT - 1));
    strobe_done  = !hit_q || slot_rdy || strobe_abort;
`else
    strobe_abort = 1'b0;
    strobe_done  = 1'b1;
`endif
  end

  // Per-slot wait-state and enable configuration.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        wait_q[i] <= '0;
      end
      en_q <= '1;
    end else if (cfg_we) begin
      wait_q[cfg_idx] <= cfg_wait;
      en_q[cfg_idx]   <= cfg_en;
    end
  end

  // Transaction FSM with registered strobes, ack, read data and status.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      hit_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_str_q <= '0;
      re_str_q <= '0;
      err_q    <= '0;
`ifdef IO_READY_TIMEOUT_EN
      tcnt_q   <= '0;
      tflag_q  <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_cyc) begin
            idx_q   <= go_idx;
            we_q    <= cpu_we;
            addr_q  <= cpu_addr[DA_W-1:0];
            wdata_q <= cpu_wdata;
            // A zero wait count skips WAIT entirely (overridden below).
            cnt_q   <= wait_q[go_idx] - 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
        end
        StStrobe: begin
          if (strobe_done) begin
            we_str_q <= '0;
            re_str_q <= '0;
            ack_q    <= 1'b1;
            state_q  <= StAck;
            if (!hit_q) begin
              if (err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
              end
              if (!we_q) begin
                rdata_q <= '1;
              end
            end else if (strobe_abort) begin
              if (!we_q) begin
                rdata_q <= '1;
              end
            end else if (!we_q) begin
              rdata_q <= slot_rdata;
            end
`ifdef IO_READY_TIMEOUT_EN
            if (strobe_abort) begin
              tflag_q <= 1'b1;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
`endif
          end
        end
        StAck: begin
          state_q <= StDone;
        end
        StDone: begin
          // A cyc still held high is never re-accepted; it must drop first.
          if (!cpu_cyc) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      if (enter_strobe) begin
        state_q  <= StStrobe;
        hit_q    <= en_q[go_idx];
        we_str_q <= go_we ? go_sel : '0;
        re_str_q <= go_we ? '0 : go_sel;
`ifdef IO_READY_TIMEOUT_EN
        tcnt_q   <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_io_bus_hub.sv
// tb_io_bus_hub: directed and randomized checks of io_bus_hub against a
// transaction-level model (per-slot wait/enable tables, expected latencies).
module tb_io_bus_hub;

  localparam int NUM_DEV = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int WAIT_W  = 3;
  localparam int TIMEOUT = 15;

  logic                      wb_clk_i = 1'b0;
  logic                      wb_rst_i;
  logic                      cpu_cyc;
  logic                      cpu_we;
  logic [ADDR_W-1:0]         cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_ack;
  logic [ADDR_W-3:0]         dev_addr;
  logic [DATA_W-1:0]         dev_wdata;
  logic [NUM_DEV-1:0]        dev_we;
  logic [NUM_DEV-1:0]        dev_re;
  logic [NUM_DEV*DATA_W-1:0] dev_rdata;
  logic [NUM_DEV-1:0]        dev_rdy;
  logic                      cfg_we;
  logic [1:0]                cfg_idx;
  logic [WAIT_W-1:0]         cfg_wait;
  logic                      cfg_en;
  logic [7:0]                err_count;
  logic                      timeout_flag;

  io_bus_hub #(
    .NUM_DEV (NUM_DEV),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WAIT_W  (WAIT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .cpu_cyc      (cpu_cyc),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .dev_addr     (dev_addr),
    .dev_wdata    (dev_wdata),
    .dev_we       (dev_we),
    .dev_re       (dev_re),
    .dev_rdata    (dev_rdata),
    .dev_rdy      (dev_rdy),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_wait     (cfg_wait),
    .cfg_en       (cfg_en),
    .err_count    (err_count),
    .timeout_flag (timeout_flag)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int         wait_m [NUM_DEV];
  bit         en_m   [NUM_DEV];
  int         err_m;
  logic [7:0] rdata_m;
  bit         tflag_m;
  logic [7:0] slot_data [NUM_DEV];

  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_rdata[i*DATA_W +: DATA_W] = slot_data[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_DEV; i++) begin
      wait_m[i] = 0;
      en_m[i]   = 1'b1;
    end
    err_m   = 0;
    rdata_m = 8'h00;
    tflag_m = 1'b0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    cpu_cyc  = 1'b0;
    cfg_we   = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    model_reset();
    @(negedge wb_clk_i);
  endtask

  task automatic do_cfg(input int idx, input int w, input bit en);
    cfg_we   = 1'b1;
    cfg_idx  = 2'(idx);
    cfg_wait = 3'(w);
    cfg_en   = en;
    @(negedge wb_clk_i);
    cfg_we   = 1'b0;
    wait_m[idx] = w;
    en_m[idx]   = en;
  endtask

  // One CPU access. hold: cycles cyc stays high after ack; drop_at: cycle at which
  // cyc is dropped early (0 = never); d: ready delay in strobe cycles.
  task automatic do_txn(input int slot, input logic [5:0] low, input bit we,
                        input logic [7:0] wd, input int hold, input int drop_at, input int d);
    int         w;
    bit         en;
    bit         timed;
    int         len;
    int         exp_ack;
    int         nstr;
    int         first;
    int         nack;
    int         ackc;
    bit         multi;
    logic [3:0] sel;
    logic [3:0] other;
    logic [5:0] s_addr;
    logic [7:0] s_wdata;
    logic [7:0] rd_ack;
    logic [7:0] exp_rd;
    logic [1:0] sl;
    w = wait_m[slot];
    en = en_m[slot];
    timed = 1'b0;
    len = 1;
    nstr = 0; first = -1; nack = 0; ackc = -1; multi = 1'b0;
    sel = '0; other = '0; s_addr = '0; s_wdata = '0; rd_ack = '0;
`ifdef IO_READY_TIMEOUT_EN
    if (en) begin
      if (d >= TIMEOUT) begin
        len = TIMEOUT;
        timed = 1'b1;
      end else begin
        len = d + 1;
      end
    end
`endif
    exp_ack = 1 + w + len;
    exp_rd = rdata_m;
    if (!we) exp_rd = (!en || timed) ? 8'hFF : slot_data[slot];

    sl = 2'(slot);
    cpu_cyc   = 1'b1;
    cpu_we    = we;
    cpu_addr  = {sl, low};
    cpu_wdata = wd;
`ifdef IO_READY_TIMEOUT_EN
    dev_rdy = '1;
    dev_rdy[slot] = 1'b0;
`else
    dev_rdy = 4'($urandom);
`endif
    for (int c = 1; c <= exp_ack + hold + 4; c++) begin
      @(negedge wb_clk_i);
      if ((dev_we | dev_re) != '0) begin
        nstr++;
        if (first < 0) begin
          first   = c;
          sel     = we ? dev_we : dev_re;
          other   = we ? dev_re : dev_we;
          s_addr  = dev_addr;
          s_wdata = dev_wdata;
        end
      end
      if ($countones(dev_we | dev_re) > 1) multi = 1'b1;
      if (cpu_ack) begin
        nack++;
        if (ackc < 0) begin
          ackc   = c;
          rd_ack = cpu_rdata;
        end
      end
`ifdef IO_READY_TIMEOUT_EN
      dev_rdy[slot] = (c >= 1 + w + d);
`else
      dev_rdy = 4'($urandom);
`endif
      if (c == drop_at || (ackc >= 0 && c >= ackc + hold)) cpu_cyc = 1'b0;
    end
    cpu_cyc = 1'b0;

    check("ack_cycle", ackc, exp_ack);
    check("ack_count", nack, 1);
    check("strobe_cycles", nstr, en ? len : 0);
    check("multi_hot", {31'd0, multi}, 0);
    if (en) begin
      check("strobe_first", first, 1 + w);
      check("strobe_sel", {28'd0, sel}, 32'd1 << slot);
      check("strobe_other", {28'd0, other}, 0);
      check("dev_addr", {26'd0, s_addr}, {26'd0, low});
      check("dev_wdata", {24'd0, s_wdata}, {24'd0, wd});
    end
    rdata_m = exp_rd;
    if (!en && err_m < 255) err_m++;
    if (timed) tflag_m = 1'b1;
    check("cpu_rdata", {24'd0, rd_ack}, {24'd0, exp_rd});
    check("err_count", {24'd0, err_count}, err_m);
    check("timeout_flag", {31'd0, timeout_flag}, {31'd0, tflag_m});
  endtask

  initial begin
    int nstr;
    wb_rst_i = 1'b1;
    cpu_cyc = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_wait = '0; cfg_en = 1'b0;
    dev_rdy = '1;
    for (int i = 0; i < NUM_DEV; i++) slot_data[i] = 8'(8'h10 + i);
    @(negedge wb_clk_i);
    do_reset();

    // Reset state
    check("rst_ack", {31'd0, cpu_ack}, 0);
    check("rst_rdata", {24'd0, cpu_rdata}, 0);
    check("rst_dev_we", {28'd0, dev_we}, 0);
    check("rst_dev_re", {28'd0, dev_re}, 0);
    check("rst_dev_addr", {26'd0, dev_addr}, 0);
    check("rst_dev_wdata", {24'd0, dev_wdata}, 0);
    check("rst_err", {24'd0, err_count}, 0);
    check("rst_tflag", {31'd0, timeout_flag}, 0);

    // Read slot 2 with no wait states
    slot_data[2] = 8'h5A;
    do_txn(2, 6'h00, 1'b0, 8'h00, 0, 0, 0);

    // Slot 1 with five wait states, write 0x33 to 0x47
    do_cfg(1, 5, 1'b1);
    do_txn(1, 6'h07, 1'b1, 8'h33, 0, 0, 0);

    // Disabled slot 3: reads return all ones, error count saturates
    do_cfg(3, 0, 1'b0);
    for (int i = 0; i < 300; i++) do_txn(3, 6'h00, 1'b0, 8'h00, 0, 0, 0);

    // cyc held high well past ack: exactly one strobe and one ack
    do_txn(0, 6'h15, 1'b0, 8'h00, 10, 0, 0);
    do_txn(0, 6'h16, 1'b1, 8'hC3, 10, 0, 0);

    // cyc dropped before ack still completes
    do_cfg(0, 3, 1'b1);
    do_txn(0, 6'h2A, 1'b0, 8'h00, 0, 2, 0);

    // Reset during WAIT with wait=7
    do_cfg(2, 7, 1'b1);
    cpu_cyc = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h81; cpu_wdata = 8'h44;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    cpu_cyc  = 1'b0;
    @(negedge wb_clk_i);
    check("mid_rst_ack", {31'd0, cpu_ack}, 0);
    check("mid_rst_rdata", {24'd0, cpu_rdata}, 0);
    check("mid_rst_err", {24'd0, err_count}, 0);
    check("mid_rst_addr", {26'd0, dev_addr}, 0);
    check("mid_rst_wdata", {24'd0, dev_wdata}, 0);
    wb_rst_i = 1'b0;
    model_reset();
    nstr = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge wb_clk_i);
      if ((dev_we | dev_re) != '0 || cpu_ack) nstr++;
    end
    check("no_strobe_after_rst", nstr, 0);
    // Config back to defaults: slot 2 has no wait, slot 3 enabled again
    slot_data[2] = 8'hA7;
    do_txn(2, 6'h01, 1'b0, 8'h00, 0, 0, 0);
    slot_data[3] = 8'h3C;
    do_txn(3, 6'h02, 1'b0, 8'h00, 0, 0, 0);

`ifdef IO_READY_TIMEOUT_EN
    slot_data[0] = 8'h96;
    do_txn(0, 6'h00, 1'b0, 8'h00, 0, 0, 3);
    do_txn(0, 6'h00, 1'b0, 8'h00, 0, 0, 100);
    slot_data[0] = 8'h69;
    do_txn(0, 6'h04, 1'b0, 8'h00, 0, 0, 0);
`endif

    // Randomized mix of configs and accesses
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < NUM_DEV; i++) slot_data[i] = 8'($urandom);
      do_txn(int'($urandom_range(0, 3)), 6'($urandom), 1'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/io_bus_hub.md
Name: io_bus_hub

Overview:
- Parametrised successor to the fixed 4-device internal IO mux used beside the AS2650 core.
- Decodes CPU IO bus cycles onto NUM_DEV peripheral slots.
- Per-slot wait states and per-slot enable, set through a config port driven by the wishbone register block.
- Registered request/ack handshake to the CPU; error/timeout status for debug readback.

Parameters:
- NUM_DEV, 4: number of device slots; power of two, 2..16.
- ADDR_W, 8: CPU IO address width.
- DATA_W, 8: data width.
- WAIT_W, 3: width of per-slot wait-state count.
- TIMEOUT, 15: max ready-wait cycles (optional feature only); must be ≥ 1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cpu_cyc  in  1  IO request; held high until cpu_ack seen, then dropped
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_cyc
- cpu_addr  in  ADDR_W  IO address; top log2(NUM_DEV) bits = slot index
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data; valid when cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- dev_addr  out  ADDR_W-log2(NUM_DEV)  latched low address bits
- dev_wdata  out  DATA_W  latched write data
- dev_we  out  NUM_DEV  one-hot write strobe
- dev_re  out  NUM_DEV  one-hot read strobe
- dev_rdata  in  NUM_DEV*DATA_W  slot read data; slot i at [i*DATA_W +: DATA_W]
- dev_rdy  in  NUM_DEV  per-slot ready (used only with optional feature)
- cfg_we  in  1  config write strobe
- cfg_idx  in  log2(NUM_DEV)  slot being configured
- cfg_wait  in  WAIT_W  wait states for cfg_idx
- cfg_en  in  1  enable for cfg_idx
- err_count  out  8  saturating count of accesses to disabled slots
- timeout_flag  out  1  sticky timeout indication

Behaviour:
- Reset: FSM=IDLE; cpu_ack=0; cpu_rdata=0; dev_we=0; dev_re=0; dev_addr=0; dev_wdata=0; err_count=0; timeout_flag=0; all wait=0; all slots enabled.
- FSM states:
  - IDLE, on cpu_cyc=1:
    - Latch cpu_we, slot index, dev_addr and dev_wdata.
    - Load cnt from wait[idx].
    - Go to WAIT.
  - WAIT:
    - cnt≠0: decrement.
    - cnt=0: go to STROBE.
  - STROBE (one cycle):
    - Assert dev_we[idx] or dev_re[idx].
    - Read: capture the dev_rdata slice into cpu_rdata at the end of this cycle.
    - Go to ACK.
  - ACK:
    - cpu_ack=1 for exactly this cycle.
    - Go to DONE.
  - DONE:
    - Wait for cpu_cyc=0, then go to IDLE.
    - Never re-accepts a still-high cyc.
- Latency: cyc sampled at edge k → strobe during cycle k+1+w → ack during cycle k+2+w, where w=wait[idx].
- Disabled slot:
  - No dev_we/dev_re asserted.
  - Wait states still honoured.
  - Read returns all ones; write dropped.
  - err_count +1 at STROBE, saturating at 255.
- Config:
  - cfg_we updates wait[cfg_idx] and en[cfg_idx] at the next edge.
  - A transaction uses the wait value latched in IDLE; a mid-transaction config write affects only later transactions.
  - Enable is sampled at STROBE.
- cpu_rdata holds its last value between reads; writes do not change it.
- cpu_cyc dropping before ack (protocol violation): transaction still completes and ack still pulses; the FSM then returns to IDLE.
- wb_rst_i mid-transaction: immediate return to IDLE with all outputs at reset values; no strobe emitted after reset.
- Outputs dev_we/dev_re are never multi-hot.

Optional Feature:
- IO_READY_TIMEOUT_EN defined:
  - STROBE holds dev_we[idx]/dev_re[idx] high while dev_rdy[idx]=0.
  - Completes (data capture, go to ACK) on the first cycle dev_rdy[idx]=1.
  - If TIMEOUT strobe cycles pass without ready: abort to ACK with cpu_rdata all ones; set timeout_flag (sticky until reset).
- Undefined:
  - dev_rdy ignored; STROBE is always one cycle.
  - timeout_flag tied 0.

Test Plan:
- Read slot 2, wait=0, dev_rdata slot2=0x5A → dev_re[2] high 1 cycle at k+1, cpu_ack at k+2, cpu_rdata=0x5A, other strobes 0.
- cfg slot 1 wait=5; write 0x33 to addr 0x47 → dev_we[1] at k+6 with dev_addr=0x07, dev_wdata=0x33; ack at k+7.
- cfg slot 3 disabled; read addr 0xC0 → no dev_re, cpu_rdata=0xFF, err_count=1; 300 such accesses → err_count saturates at 255.
- cpu_cyc held high 10 cycles after ack → exactly one strobe and one ack; next transaction only after cyc low then high.
- Assert wb_rst_i during WAIT (wait=7) → outputs reset next cycle, no strobe; wait config returns to 0.
- IO_READY_TIMEOUT_EN: dev_rdy[0] low 3 cycles → ack after ready, data captured; dev_rdy[0] held low → ack after 15 strobe cycles, rdata 0xFF, timeout_flag=1.
